// File: rtl/alu_issue_pkg.sv
// Shared MIPS decode package (mips_define): opcode/funct constants, ALU oper codes,
// buffer states and the issue-packet struct used by alu_issue and its decoder.
package mips_define;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] EXE_ALU_ADD = 4'd0;
    localparam logic [3:0] EXE_ALU_SUB = 4'd1;
    localparam logic [3:0] EXE_ALU_SLT = 4'd2;
    localparam logic [3:0] EXE_ALU_AND = 4'd3;
    localparam logic [3:0] EXE_ALU_OR  = 4'd4;
    localparam logic [3:0] EXE_ALU_LUI = 4'd5;
    localparam logic [3:0] EXE_ALU_XOR = 4'd6;
    localparam logic [3:0] EXE_ALU_NOR = 4'd7;
    localparam logic [3:0] EXE_ALU_SL  = 4'd8;
    localparam logic [3:0] EXE_ALU_SR  = 4'd9;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  oper;
        logic        sign;
        logic [4:0]  wb_addr;
        logic        wb_en;
        logic        illegal;
    } issue_pkt_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'b0, imm};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ID-side and EX-side handshake bundle of the ALU issue stage.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_oper;
    logic        ex_sign;
    logic [4:0]  ex_wb_addr;
    logic        ex_wb_en;
    logic        ex_illegal;

    modport master (
        output flush, in_valid, in_inst, in_rs_data, in_rt_data, ex_ready,
        input  in_ready, ex_valid, ex_a, ex_b, ex_oper, ex_sign, ex_wb_addr, ex_wb_en,
               ex_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_rs_data, in_rt_data, ex_ready,
        output in_ready, ex_valid, ex_a, ex_b, ex_oper, ex_sign, ex_wb_addr, ex_wb_en,
               ex_illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of one MIPS ALU-class instruction into an issue packet.
module alu_decode
    import mips_define::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output issue_pkt_t  pkt
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [4:0] dest;
    logic       legal;
    logic [4:0] unused_rs_field;

    assign opcode          = inst[31:26];
    assign rt              = inst[20:16];
    assign rd              = inst[15:11];
    assign shamt           = inst[10:6];
    assign funct           = inst[5:0];
    // rs arrives already read and forwarded, so its index is not needed here
    assign unused_rs_field = inst[25:21];

    always_comb begin
        legal       = 1'b1;
        dest        = rd;
        pkt.a       = rs_data;
        pkt.b       = rt_data;
        pkt.oper    = EXE_ALU_ADD;
        pkt.sign    = 1'b0;
        pkt.wb_addr = 5'd0;
        pkt.wb_en   = 1'b0;
        pkt.illegal = 1'b0;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_ADD, FN_ADDU: pkt.oper = EXE_ALU_ADD;
                FN_SUB, FN_SUBU: pkt.oper = EXE_ALU_SUB;
                FN_AND:  pkt.oper = EXE_ALU_AND;
                FN_OR:   pkt.oper = EXE_ALU_OR;
                FN_XOR:  pkt.oper = EXE_ALU_XOR;
                FN_NOR:  pkt.oper = EXE_ALU_NOR;
                FN_SLT:  pkt.oper = EXE_ALU_SLT;
                FN_SLTU: begin pkt.oper = EXE_ALU_SLT; pkt.sign = 1'b1; end
                FN_SLL:  begin pkt.oper = EXE_ALU_SL; pkt.a = {27'b0, shamt}; end
                FN_SRL:  begin pkt.oper = EXE_ALU_SR; pkt.a = {27'b0, shamt}; end
                FN_SRA: begin
                    pkt.oper = EXE_ALU_SR;
                    pkt.sign = 1'b1;
                    pkt.a    = {27'b0, shamt};
                end
                FN_SLLV: begin pkt.oper = EXE_ALU_SL; pkt.a = {27'b0, rs_data[4:0]}; end
                FN_SRLV: begin pkt.oper = EXE_ALU_SR; pkt.a = {27'b0, rs_data[4:0]}; end
                FN_SRAV: begin
                    pkt.oper = EXE_ALU_SR;
                    pkt.sign = 1'b1;
                    pkt.a    = {27'b0, rs_data[4:0]};
                end
                default: legal = 1'b0;
            endcase
        end else begin
            dest = rt;
            case (opcode)
                OP_ADDI, OP_ADDIU: pkt.b = sext16(inst[15:0]);
                OP_SLTI:  begin pkt.oper = EXE_ALU_SLT; pkt.b = sext16(inst[15:0]); end
                OP_SLTIU: begin
                    pkt.oper = EXE_ALU_SLT;
                    pkt.sign = 1'b1;
                    pkt.b    = sext16(inst[15:0]);
                end
                OP_ANDI: begin pkt.oper = EXE_ALU_AND; pkt.b = zext16(inst[15:0]); end
                OP_ORI:  begin pkt.oper = EXE_ALU_OR;  pkt.b = zext16(inst[15:0]); end
                OP_XORI: begin pkt.oper = EXE_ALU_XOR; pkt.b = zext16(inst[15:0]); end
                OP_LUI: begin
                    pkt.oper = EXE_ALU_LUI;
                    pkt.a    = 32'd0;
                    pkt.b    = zext16(inst[15:0]);
                end
                default: legal = 1'b0;
            endcase
        end

        if (!legal) begin
            pkt.a       = 32'd0;
            pkt.b       = 32'd0;
            pkt.oper    = EXE_ALU_ADD;
            pkt.sign    = 1'b0;
            pkt.wb_addr = 5'd0;
            pkt.wb_en   = 1'b0;
            pkt.illegal = 1'b1;
        end else begin
            pkt.wb_addr = dest;
            pkt.wb_en   = |dest;
        end
    end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes into a registered EX packet behind valid/ready with flush.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module alu_issue
    import mips_define::*;
(
    input logic         clk,
    input logic         rst_n,
    alu_issue_if.slave  bus
);
    issue_pkt_t dec_pkt;
    issue_pkt_t out_q, out_d;
    buf_state_e state_q, state_d;
    logic       accept;
    logic       drain;

    alu_decode u_decode (
        .inst    (bus.in_inst),
        .rs_data (bus.in_rs_data),
        .rt_data (bus.in_rt_data),
        .pkt     (dec_pkt)
    );

    assign drain = (state_q != StEmpty) && bus.ex_ready;

`ifdef ALU_ISSUE_SKID_EN
    issue_pkt_t skid_q, skid_d;
    logic       in_ready_q;

    assign accept       = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_d   = dec_pkt;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && !drain) begin
                        skid_d  = dec_pkt;
                        state_d = StTwo;
                    end else if (accept && drain) begin
                        out_d = dec_pkt;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        out_d   = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end
`else
    assign bus.in_ready = (state_q == StEmpty) || bus.ex_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            out_d   = dec_pkt;
            state_d = StOne;
        end else if (drain) begin
            state_d = StEmpty;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.ex_valid   = (state_q != StEmpty);
    assign bus.ex_a       = out_q.a;
    assign bus.ex_b       = out_q.b;
    assign bus.ex_oper    = out_q.oper;
    assign bus.ex_sign    = out_q.sign;
    assign bus.ex_wb_addr = out_q.wb_addr;
    assign bus.ex_wb_en   = out_q.wb_en;
    assign bus.ex_illegal = out_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Randomised scoreboard bench for alu_issue with directed corner cases.
module tb_alu_issue;
    import mips_define::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [75:0] sb[$];
    logic        prev_stalled;
    logic [75:0] prev_pkt;
    logic [5:0]  fn_list[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] out_bits();
        return {bus.ex_a, bus.ex_b, bus.ex_oper, bus.ex_sign, bus.ex_wb_addr, bus.ex_wb_en,
                bus.ex_illegal};
    endfunction

    // What the ALU should be told to do, derived from MIPS instruction semantics
    function automatic logic [75:0] model(input logic [31:0] inst, input logic [31:0] rs,
                                          input logic [31:0] rt);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] imm_s;
        logic [31:0] imm_z;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  oper;
        logic        sign;
        logic [4:0]  dst;
        bit          ok;
        op    = inst[31:26];
        fn    = inst[5:0];
        imm_s = {{16{inst[15]}}, inst[15:0]};
        imm_z = {16'h0000, inst[15:0]};
        a     = rs;
        b     = rt;
        sign  = 1'b0;
        ok    = 1'b1;
        oper  = EXE_ALU_ADD;
        if (op == 6'd0) begin
            dst = inst[15:11];
            case (fn)
                6'h20, 6'h21: oper = EXE_ALU_ADD;
                6'h22, 6'h23: oper = EXE_ALU_SUB;
                6'h24: oper = EXE_ALU_AND;
                6'h25: oper = EXE_ALU_OR;
                6'h26: oper = EXE_ALU_XOR;
                6'h27: oper = EXE_ALU_NOR;
                6'h2A: oper = EXE_ALU_SLT;
                6'h2B: begin oper = EXE_ALU_SLT; sign = 1'b1; end
                6'h00: begin oper = EXE_ALU_SL; a = 32'(inst[10:6]); end
                6'h02: begin oper = EXE_ALU_SR; a = 32'(inst[10:6]); end
                6'h03: begin oper = EXE_ALU_SR; sign = 1'b1; a = 32'(inst[10:6]); end
                6'h04: begin oper = EXE_ALU_SL; a = rs % 32; end
                6'h06: begin oper = EXE_ALU_SR; a = rs % 32; end
                6'h07: begin oper = EXE_ALU_SR; sign = 1'b1; a = rs % 32; end
                default: ok = 1'b0;
            endcase
        end else begin
            dst = inst[20:16];
            case (op)
                6'h08, 6'h09: b = imm_s;
                6'h0A: begin oper = EXE_ALU_SLT; b = imm_s; end
                6'h0B: begin oper = EXE_ALU_SLT; sign = 1'b1; b = imm_s; end
                6'h0C: begin oper = EXE_ALU_AND; b = imm_z; end
                6'h0D: begin oper = EXE_ALU_OR;  b = imm_z; end
                6'h0E: begin oper = EXE_ALU_XOR; b = imm_z; end
                6'h0F: begin oper = EXE_ALU_LUI; a = 32'd0; b = imm_z; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) return {32'd0, 32'd0, EXE_ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b1};
        return {a, b, oper, sign, dst, dst != 5'd0, 1'b0};
    endfunction

    function automatic logic [31:0] rand_inst();
        int unsigned r;
        logic [31:0] base;
        logic [5:0]  bad_ops[3];
        bad_ops = '{6'h3F, 6'h23, 6'h02};
        r       = $urandom_range(0, 9);
        base    = $urandom;
        if (r == 0) return {6'd0, base[25:6], 6'h08};
        if (r < 5) return {6'd0, base[25:6], fn_list[$urandom_range(0, 15)]};
        if (r < 9) return {6'(8 + $urandom_range(0, 7)), base[25:0]};
        return {bad_ops[$urandom_range(0, 2)], base[25:0]};
    endfunction

    // Scoreboard monitor: pops on every EX transfer, pushes on every accepted instruction
    always @(negedge clk) begin
        logic [75:0] cur;
        logic [75:0] exp;
        if (!rst_n || bus.flush) begin
            sb.delete();
            prev_stalled = 1'b0;
        end else begin
            cur = out_bits();
            if (prev_stalled) check("stall_hold", cur, prev_pkt);
            if (bus.ex_valid && bus.ex_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_pkt actual=%h required=none", cur);
                end else begin
                    exp = sb.pop_front();
                    if (exp[0]) begin
                        cur[6:2] = 5'd0;
                        exp[6:2] = 5'd0;
                    end
                    check("ex_pkt", cur, exp);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_inst, bus.in_rs_data, bus.in_rt_data));
            prev_stalled = bus.ex_valid && !bus.ex_ready;
            prev_pkt     = out_bits();
        end
    end

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] rs,
                        input logic [31:0] rt, input logic er, input logic fl,
                        output logic acc);
        bus.in_valid   = v;
        bus.in_inst    = inst;
        bus.in_rs_data = rs;
        bus.in_rt_data = rt;
        bus.ex_ready   = er;
        bus.flush      = fl;
        #1;
        acc = v && bus.in_ready && !fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [31:0] prog[3];
        int          idx;
        n_total      = 0;
        n_bad        = 0;
        prev_stalled = 1'b0;
        prev_pkt     = '0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst  = 32'd0;
        bus.in_rs_data = 32'd0;
        bus.in_rt_data = 32'd0;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", 76'(bus.ex_valid), 76'd0);
        check("reset_in_ready", 76'(bus.in_ready), 76'd1);
        check("reset_outputs", out_bits(), 76'd0);
        rst_n = 1'b1;
        idle(1);

        // ADDI $5, $1, -1
        step(1'b1, {6'h08, 5'd1, 5'd5, 16'hFFFF}, 32'h10, 32'h0, 1'b1, 1'b0, acc);
        check("addi_valid", 76'(bus.ex_valid), 76'd1);
        check("addi_pkt", out_bits(),
              {32'h10, 32'hFFFF_FFFF, EXE_ALU_ADD, 1'b0, 5'd5, 1'b1, 1'b0});
        idle(1);

        // SRA $3, $2, 4
        step(1'b1, {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 32'h0, 32'h8000_0000, 1'b1, 1'b0,
             acc);
        check("sra_pkt", out_bits(),
              {32'd4, 32'h8000_0000, EXE_ALU_SR, 1'b1, 5'd3, 1'b1, 1'b0});
        idle(1);

        // Opcode 0x3F is not ALU-class
        step(1'b1, {6'h3F, 26'h3AB_CDEF}, 32'h1234, 32'h5678, 1'b1, 1'b0, acc);
        check("illegal_flags", 76'({bus.ex_illegal, bus.ex_wb_en}), 76'b10);
        check("illegal_ops", 76'({bus.ex_a, bus.ex_b, bus.ex_oper}), 76'd0);
        idle(1);

        // ADD $0, $1, $2
        step(1'b1, {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'h1, 32'h2, 1'b1, 1'b0, acc);
        check("add_rd0_wb_en", 76'(bus.ex_wb_en), 76'd0);
        idle(1);

        // SLTU, ORI, LUI back-to-back with EX stalled for three cycles
        prog[0] = {6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h2B};
        prog[1] = {6'h0D, 5'd3, 5'd8, 16'hA5A5};
        prog[2] = {6'h0F, 5'd0, 5'd9, 16'h1234};
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            step(1'b1, prog[idx], 32'hFFFF_0000 + 32'(idx), 32'h0000_0100, cyc >= 3, 1'b0, acc);
            if (acc) idx++;
            if (cyc == 1) begin
`ifdef ALU_ISSUE_SKID_EN
                check("stall_accepts", 76'(idx), 76'd2);
`else
                check("stall_accepts", 76'(idx), 76'd1);
`endif
                check("stall_in_ready", 76'(bus.in_ready), 76'd0);
            end
        end
        check("stall_all_issued", 76'(idx), 76'd3);
        idle(3);
        check("stall_drained", 76'(sb.size()), 76'd0);

        // Flush with the buffer full and a new instruction offered
        step(1'b1, prog[0], 32'h1, 32'h2, 1'b0, 1'b0, acc);
        step(1'b1, prog[1], 32'h3, 32'h4, 1'b0, 1'b0, acc);
        step(1'b1, prog[2], 32'h5, 32'h6, 1'b0, 1'b1, acc);
        check("flush_ex_valid", 76'(bus.ex_valid), 76'd0);
        check("flush_in_ready", 76'(bus.in_ready), 76'd1);
        idle(3);
        check("flush_stays_empty", 76'(bus.ex_valid), 76'd0);

        // Asynchronous reset while a packet is waiting
        step(1'b1, {6'h08, 5'd1, 5'd5, 16'h7FFF}, 32'h55, 32'h0, 1'b0, 1'b0, acc);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_ex_valid", 76'(bus.ex_valid), 76'd0);
        check("areset_in_ready", 76'(bus.in_ready), 76'd1);
        check("areset_outputs", out_bits(), 76'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Random traffic with random back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, acc);
        end
        idle(4);
        check("final_drained", 76'(sb.size()), 76'd0);
        check("final_ex_valid", 76'(bus.ex_valid), 76'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
